// File: rtl/radix_seq_pkg.sv
// radix_seq_pkg: mode codes, sequencer states and error-bit indices shared by the radix sequencer.
package radix_seq_pkg;
  localparam logic [1:0] MODE_HALF   = 2'd0;
  localparam logic [1:0] MODE_SINGLE = 2'd1;
  localparam logic [1:0] MODE_DOUBLE = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;
  typedef enum logic [1:0] {ST_FLUSH, ST_RUN, ST_DRAIN, ST_SWITCH} state_e;
  localparam int ERR_MODE  = 0;
  localparam int ERR_UFLOW = 1;
endpackage

// File: rtl/radix_seq_inflight_cnt.sv
// radix_seq_inflight_cnt: saturating up/down count of accepted-but-unreturned beats.
module radix_seq_inflight_cnt #(
  parameter int MAX = 32,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rstn,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty,
  output logic underflow
);
  logic [W-1:0] cnt_q, cnt_d;
  assign full      = cnt_q == W'(MAX);
  assign empty     = cnt_q == '0;
  assign underflow = dec & ~inc & empty;
  always_comb cnt_d = (inc & ~dec & ~full) ? cnt_q + W'(1) :
                      (dec & ~inc & ~empty) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
endmodule

// File: rtl/radix_mode_sequencer.sv
// radix_mode_sequencer: owns converter Ctrl_sig, gates input beats and merges result streams.
// Optional per-mode result counters are built when RADIX_SEQ_STATS_EN is defined.
module radix_mode_sequencer
  import radix_seq_pkg::*;
#(
  parameter int         MAX_INFLIGHT = 32,
  parameter logic [1:0] DEF_MODE     = MODE_DOUBLE,
  parameter int         FLUSH_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         cfg_mode_valid,
  output logic         cfg_mode_ready,
  input  logic [1:0]   cfg_mode,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [255:0] s_data,
  output logic [1:0]   conv_ctrl_sig,
  output logic         conv_in_valid,
  input  logic         conv_in_ready,
  output logic [255:0] conv_in_data,
  input  logic         dbl_valid,
  input  logic         sgl_valid,
  input  logic         hlf_valid,
  output logic         dbl_ready,
  output logic         sgl_ready,
  output logic         hlf_ready,
  input  logic [63:0]  dbl_data,
  input  logic [31:0]  sgl_data,
  input  logic [15:0]  hlf_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [63:0]  m_data,
  output logic [1:0]   err_flags,
  output logic [31:0]  stat_cnt_dbl,
  output logic [31:0]  stat_cnt_sgl,
  output logic [31:0]  stat_cnt_hlf
);
  localparam int FT_W = $clog2(FLUSH_CYCLES + 1);
  state_e state_q, state_d;
  logic [1:0] ctrl_q, ctrl_d, pend_q, pend_d, err_q, err_d;
  logic [FT_W-1:0] flush_q, flush_d;
  logic run, live, sel_valid, sel_ready, inc, dec, full, empty, uflow;
  assign run            = state_q == ST_RUN;
  assign live           = run || state_q == ST_DRAIN;
  assign cfg_mode_ready = run;
  assign conv_in_valid  = run & s_valid & ~full;
  assign s_ready        = run & conv_in_ready & ~full;
  assign conv_in_data   = s_data;
  assign conv_ctrl_sig  = ctrl_q;
  assign err_flags      = err_q;
  assign sel_valid = ctrl_q == MODE_DOUBLE ? dbl_valid : ctrl_q == MODE_SINGLE ? sgl_valid : hlf_valid;
  assign m_data    = ctrl_q == MODE_DOUBLE ? dbl_data : ctrl_q == MODE_SINGLE ? {32'b0, sgl_data} : {48'b0, hlf_data};
  assign m_valid   = live & sel_valid;
  // FLUSH sinks stale converter output; SWITCH holds everything so ctrl can change cleanly.
  assign sel_ready = live ? m_ready : state_q == ST_FLUSH;
  assign dbl_ready = sel_ready & (ctrl_q == MODE_DOUBLE);
  assign sgl_ready = sel_ready & (ctrl_q == MODE_SINGLE);
  assign hlf_ready = sel_ready & (ctrl_q != MODE_DOUBLE) & (ctrl_q != MODE_SINGLE);
  assign inc = conv_in_valid & conv_in_ready;
  assign dec = m_valid & m_ready;
  radix_seq_inflight_cnt #(.MAX(MAX_INFLIGHT)) u_cnt (
    .clk(clk), .rstn(rstn), .inc(inc), .dec(dec),
    .full(full), .empty(empty), .underflow(uflow)
  );
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    pend_d  = pend_q;
    flush_d = flush_q;
    err_d   = err_q;
    err_d[ERR_UFLOW] = err_q[ERR_UFLOW] | uflow;
    case (state_q)
      ST_FLUSH: begin
        flush_d = flush_q + FT_W'(1);
        state_d = flush_q == FT_W'(FLUSH_CYCLES - 1) ? ST_RUN : ST_FLUSH;
      end
      ST_RUN:
        if (cfg_mode_valid) begin
          if (cfg_mode == MODE_RSVD) err_d[ERR_MODE] = 1'b1;
          else if (cfg_mode != ctrl_q) begin
            pend_d  = cfg_mode;
            state_d = ST_DRAIN;
          end
        end
      ST_DRAIN: state_d = empty ? ST_SWITCH : ST_DRAIN;
      ST_SWITCH: begin
        ctrl_d  = pend_q;
        state_d = ST_RUN;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= ST_FLUSH;
      ctrl_q  <= DEF_MODE;
      pend_q  <= DEF_MODE;
      flush_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      pend_q  <= pend_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
`ifdef RADIX_SEQ_STATS_EN
  logic [31:0] dbl_q, sgl_q, hlf_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      dbl_q <= '0;
      sgl_q <= '0;
      hlf_q <= '0;
    end else if (dec) begin
      if (ctrl_q == MODE_DOUBLE) dbl_q <= dbl_q + 32'd1;
      else if (ctrl_q == MODE_SINGLE) sgl_q <= sgl_q + 32'd1;
      else hlf_q <= hlf_q + 32'd1;
    end
  assign stat_cnt_dbl = dbl_q;
  assign stat_cnt_sgl = sgl_q;
  assign stat_cnt_hlf = hlf_q;
`else
  assign stat_cnt_dbl = '0;
  assign stat_cnt_sgl = '0;
  assign stat_cnt_hlf = '0;
`endif
endmodule

// File: tb/tb_radix_mode_sequencer.sv
// tb_radix_mode_sequencer: directed self-checking bench for radix_mode_sequencer.
module tb_radix_mode_sequencer;
  logic clk = 1'b0, rstn = 1'b0;
  logic cfg_mode_valid = 0, cfg_mode_ready;
  logic [1:0] cfg_mode = 0;
  logic s_valid = 0, s_ready;
  logic [255:0] s_data = '0;
  logic [1:0] conv_ctrl_sig;
  logic conv_in_valid, conv_in_ready = 0;
  logic [255:0] conv_in_data;
  logic dbl_valid = 0, sgl_valid = 0, hlf_valid = 0;
  logic dbl_ready, sgl_ready, hlf_ready;
  logic [63:0] dbl_data = '0;
  logic [31:0] sgl_data = '0;
  logic [15:0] hlf_data = '0;
  logic m_valid, m_ready = 0;
  logic [63:0] m_data;
  logic [1:0] err_flags;
  logic [31:0] stat_cnt_dbl, stat_cnt_sgl, stat_cnt_hlf;
  int checks = 0, errors = 0;
  logic [63:0] exp64;
  radix_mode_sequencer dut (
    .clk(clk), .rstn(rstn),
    .cfg_mode_valid(cfg_mode_valid), .cfg_mode_ready(cfg_mode_ready), .cfg_mode(cfg_mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .conv_ctrl_sig(conv_ctrl_sig), .conv_in_valid(conv_in_valid),
    .conv_in_ready(conv_in_ready), .conv_in_data(conv_in_data),
    .dbl_valid(dbl_valid), .sgl_valid(sgl_valid), .hlf_valid(hlf_valid),
    .dbl_ready(dbl_ready), .sgl_ready(sgl_ready), .hlf_ready(hlf_ready),
    .dbl_data(dbl_data), .sgl_data(sgl_data), .hlf_data(hlf_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .err_flags(err_flags),
    .stat_cnt_dbl(stat_cnt_dbl), .stat_cnt_sgl(stat_cnt_sgl), .stat_cnt_hlf(stat_cnt_hlf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctrl", 64'(conv_ctrl_sig), 64'd2);
    chk("rst_err", 64'(err_flags), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_cfg_ready", 64'(cfg_mode_ready), 64'd0);
    chk("rst_stat_dbl", 64'(stat_cnt_dbl), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    s_valid = 1;
    conv_in_ready = 1;
    m_ready = 1;
    // flush: 5 stale results in the first 10 cycles, none may escape
    for (int c = 0; c < 63; c++) begin
      dbl_valid = (c < 10) && (c % 2 == 0);
      dbl_data = 64'hBAD0_0000_0000_0000 | 64'(c);
      #1;
      chk("flush_m_valid", 64'(m_valid), 64'd0);
      chk("flush_s_ready", 64'(s_ready | conv_in_valid), 64'd0);
      chk("flush_cfg_ready", 64'(cfg_mode_ready), 64'd0);
      chk("flush_dbl_ready", 64'(dbl_ready), 64'd1);
      chk("flush_sgl_ready", 64'(sgl_ready), 64'd0);
      @(negedge clk);
    end
    s_valid = 0;
    dbl_valid = 0;
    m_ready = 0;
    #1;
    chk("flush_63_cfg_ready", 64'(cfg_mode_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("run_at_64", 64'(cfg_mode_ready), 64'd1);
    chk("flush_err", 64'(err_flags), 64'd0);
    // 10 double beats in, then 10 results out
    for (int i = 0; i < 10; i++) begin
      s_valid = 1;
      s_data = {4{64'hA5A5_0000_0000_0000 | 64'(i)}};
      #1;
      chk("t2_s_ready", 64'(s_ready), 64'd1);
      chk("t2_in_valid", 64'(conv_in_valid), 64'd1);
      chk("t2_in_data", conv_in_data[255:192], 64'hA5A5_0000_0000_0000 | 64'(i));
      @(negedge clk);
    end
    s_valid = 0;
    m_ready = 1;
    dbl_valid = 1;
    for (int i = 0; i < 10; i++) begin
      dbl_data = 64'hD000_1111_0000_0000 | 64'(i);
      #1;
      chk("t2_m_valid", 64'(m_valid), 64'd1);
      chk("t2_m_data", m_data, 64'hD000_1111_0000_0000 | 64'(i));
      chk("t2_dbl_ready", 64'(dbl_ready), 64'd1);
      @(negedge clk);
    end
    dbl_valid = 0;
    #1;
    chk("t2_err", 64'(err_flags), 64'd0);
`ifdef RADIX_SEQ_STATS_EN
    chk("t2_stat_dbl", 64'(stat_cnt_dbl), 64'd10);
`else
    chk("t2_stat_dbl", 64'(stat_cnt_dbl), 64'd0);
`endif
    // 8 in flight, request half while blocked downstream
    m_ready = 0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1;
      s_data = 256'(i);
      #1;
      chk("t3_s_ready", 64'(s_ready), 64'd1);
      @(negedge clk);
    end
    s_valid = 0;
    cfg_mode_valid = 1;
    cfg_mode = 2'd0;
    #1;
    chk("t3_cfg_ready", 64'(cfg_mode_ready), 64'd1);
    @(negedge clk);
    cfg_mode_valid = 0;
    s_valid = 1;
    #1;
    chk("t3_drain_s_ready", 64'(s_ready), 64'd0);
    chk("t3_drain_in_valid", 64'(conv_in_valid), 64'd0);
    chk("t3_drain_ctrl", 64'(conv_ctrl_sig), 64'd2);
    chk("t3_drain_cfg_ready", 64'(cfg_mode_ready), 64'd0);
    s_valid = 0;
    m_ready = 1;
    dbl_valid = 1;
    for (int i = 0; i < 8; i++) begin
      dbl_data = 64'hCAFE_0000_0000_0000 | 64'(i);
      #1;
      chk("t3_drain_m_data", m_data, 64'hCAFE_0000_0000_0000 | 64'(i));
      chk("t3_drain_m_valid", 64'(m_valid), 64'd1);
      chk("t3_drain_ctrl_hold", 64'(conv_ctrl_sig), 64'd2);
      @(negedge clk);
    end
    dbl_valid = 0;
    #1;
    chk("t3_empty_ctrl", 64'(conv_ctrl_sig), 64'd2);
    @(negedge clk);
    dbl_valid = 1;
    s_valid = 1;
    #1;
    chk("t3_switch_ctrl", 64'(conv_ctrl_sig), 64'd2);
    chk("t3_switch_m_valid", 64'(m_valid), 64'd0);
    chk("t3_switch_dbl_ready", 64'(dbl_ready), 64'd0);
    chk("t3_switch_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    dbl_valid = 0;
    s_valid = 0;
    #1;
    chk("t3_new_ctrl", 64'(conv_ctrl_sig), 64'd0);
    chk("t3_run_cfg_ready", 64'(cfg_mode_ready), 64'd1);
    s_valid = 1;
    #1;
    chk("t3_half_s_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    s_valid = 0;
    hlf_valid = 1;
    hlf_data = 16'hBEEF;
    sgl_valid = 1;
    sgl_data = 32'h1234_5678;
    dbl_valid = 1;
    dbl_data = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("t3_half_m_data", m_data, 64'h0000_0000_0000_BEEF);
    chk("t3_half_m_valid", 64'(m_valid), 64'd1);
    chk("t3_half_readies", 64'({hlf_ready, sgl_ready, dbl_ready}), 64'b100);
    @(negedge clk);
    hlf_valid = 0;
    sgl_valid = 0;
    dbl_valid = 0;
`ifdef RADIX_SEQ_STATS_EN
    #1;
    chk("t3_stat_hlf", 64'(stat_cnt_hlf), 64'd1);
`endif
    // fill to MAX_INFLIGHT=32 with the output blocked
    m_ready = 0;
    s_valid = 1;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("t4_fill_s_ready", 64'(s_ready), 64'd1);
      @(negedge clk);
    end
    #1;
    chk("t4_full_s_ready", 64'(s_ready), 64'd0);
    chk("t4_full_in_valid", 64'(conv_in_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("t4_full_hold", 64'(s_ready), 64'd0);
    s_valid = 0;
    m_ready = 1;
    hlf_valid = 1;
    repeat (32) @(negedge clk);
    hlf_valid = 0;
    #1;
    chk("t4_err", 64'(err_flags), 64'd0);
    // switch to single and check zero extension
    cfg_mode_valid = 1;
    cfg_mode = 2'd1;
    @(negedge clk);
    cfg_mode_valid = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("t5_sgl_ctrl", 64'(conv_ctrl_sig), 64'd1);
    s_valid = 1;
    @(negedge clk);
    s_valid = 0;
    sgl_valid = 1;
    sgl_data = 32'hDEAD_BEEF;
    hlf_valid = 1;
    #1;
    chk("t5_sgl_m_data", m_data, 64'h0000_0000_DEAD_BEEF);
    chk("t5_sgl_readies", 64'({hlf_ready, sgl_ready, dbl_ready}), 64'b010);
    @(negedge clk);
    sgl_valid = 0;
    hlf_valid = 0;
    // reserved mode and spurious result
    cfg_mode_valid = 1;
    cfg_mode = 2'd3;
    @(negedge clk);
    cfg_mode_valid = 0;
    #1;
    chk("t6_rsvd_err", 64'(err_flags), 64'b01);
    chk("t6_rsvd_ctrl", 64'(conv_ctrl_sig), 64'd1);
    chk("t6_rsvd_stay_run", 64'(cfg_mode_ready), 64'd1);
    sgl_valid = 1;
    @(negedge clk);
    sgl_valid = 0;
    #1;
    chk("t6_uflow_err", 64'(err_flags), 64'b11);
    cfg_mode_valid = 1;
    cfg_mode = 2'd0;
    @(negedge clk);
    cfg_mode_valid = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("t6_count_zero_switch", 64'(conv_ctrl_sig), 64'd0);
    // reset in the middle of a drain
    m_ready = 0;
    s_valid = 1;
    @(negedge clk);
    s_valid = 0;
    cfg_mode_valid = 1;
    cfg_mode = 2'd1;
    @(negedge clk);
    cfg_mode_valid = 0;
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("t7_rst_ctrl", 64'(conv_ctrl_sig), 64'd2);
    chk("t7_rst_err", 64'(err_flags), 64'd0);
    chk("t7_rst_cfg_ready", 64'(cfg_mode_ready), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (63) @(negedge clk);
    #1;
    chk("t7_flush_again", 64'(cfg_mode_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("t7_run_again", 64'(cfg_mode_ready), 64'd1);
    chk("t7_ctrl_def", 64'(conv_ctrl_sig), 64'd2);
    exp64 = 64'd0;
    chk("t7_err_clear", 64'(err_flags), exp64);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
